// File: rtl/aes_mix_columns_ctrl.sv
// AES MixColumns / InvMixColumns sequencer: time-multiplexes COLS_PER_CYCLE
// single-column mixers over the four columns of a 128-bit state held in place.

module aes_mix_single_column (
    input  logic        op_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m3 [4];
    logic [7:0] m9 [4];
    logic [7:0] m11[4];
    logic [7:0] m13[4];
    logic [7:0] m14[4];

    always_comb begin
        data_o = '0;
        for (int r = 0; r < 4; r++) begin
            a[r]   = data_i[r*8 +: 8];
            x2[r]  = xtime(a[r]);
            x4[r]  = xtime(x2[r]);
            x8[r]  = xtime(x4[r]);
            m3[r]  = x2[r] ^ a[r];
            m9[r]  = x8[r] ^ a[r];
            m11[r] = x8[r] ^ x2[r] ^ a[r];
            m13[r] = x8[r] ^ x4[r] ^ a[r];
            m14[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        // Circulant matrices: forward {2,3,1,1}, inverse {14,11,13,9}.
        for (int r = 0; r < 4; r++) begin
            if (op_i) begin
                data_o[r*8 +: 8] = m14[r] ^ m11[(r+1)%4] ^ m13[(r+2)%4] ^ m9[(r+3)%4];
            end else begin
                data_o[r*8 +: 8] = x2[r] ^ m3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
    end

endmodule

module aes_mix_columns_ctrl #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         op_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o,
    output logic         busy_o
);

    localparam int NUM_STEPS = 4 / COLS_PER_CYCLE;
    localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("aes_mix_columns_ctrl: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready/valid here are pure decodes of the FSM, never of inputs.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t              fsm_q, fsm_d;
    logic [127:0]      state_q, state_d;
    logic              op_q, op_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic [1:0]  col_sel [COLS_PER_CYCLE];
    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] w;
        w = '0;
        for (int row = 0; row < 4; row++) begin
            w[row*8 +: 8] = s[((row*4) + int'(c))*8 +: 8];
        end
        return w;
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] w);
        logic [127:0] res;
        res = s;
        for (int row = 0; row < 4; row++) begin
            res[((row*4) + int'(c))*8 +: 8] = w[row*8 +: 8];
        end
        return res;
    endfunction

    generate
        for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
            assign col_sel[i] = 2'((int'(step_q) * COLS_PER_CYCLE) + i);
            assign col_in[i]  = get_col(state_q, col_sel[i]);

            aes_mix_single_column u_mix (
                .op_i   (op_q),
                .data_i (col_in[i]),
                .data_o (col_out[i])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            op_q    <= 1'b0;
            step_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            op_q    <= op_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        op_d    = op_q;
        step_d  = step_q;
        if (clear_i) begin
            fsm_d   = IDLE;
            state_d = '0;
            op_d    = 1'b0;
            step_d  = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_d = data_i;
                        op_d    = op_i;
                        step_d  = '0;
                        fsm_d   = CALC;
                    end
                end
                CALC: begin
                    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
                        state_d = put_col(state_d, col_sel[i], col_out[i]);
                    end
                    if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                        fsm_d  = DONE;
                        step_d = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        fsm_d = IDLE;
                    end
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign busy_o      = (fsm_q != IDLE);
    assign data_o      = state_q;

endmodule
